// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline control slice.
package lc3b_types;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pipe_fsm_t;

  localparam int LC3B_NUM_STAGES = 5;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Youngest-producer match for one ID source operand against pipeline
// registers 1..last. Index 0 of the inputs corresponds to register 1.
module pipe_fwd_sel #(
  parameter  int NUM_STAGES = 5,
  parameter  int REG_W      = 3,
  localparam int NR         = NUM_STAGES - 1,
  localparam int SEL_W      = $clog2(NUM_STAGES)
) (
  input  logic [REG_W-1:0]        src_i,
  input  logic                    src_used_i,
  input  logic [NR-2:0]           stg_valid_i,
  input  logic [NR-2:0]           stg_wr_i,
  input  logic [(NR-1)*REG_W-1:0] stg_dest_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    hit_o,
  output logic                    hit_first_o
);

  logic [NR-2:0] match;

  // A register matches when it holds a live regfile write to this source.
  always_comb begin
    match = '0;
    for (int j = 0; j < NR - 1; j++) begin
      match[j] = src_used_i & stg_valid_i[j] & stg_wr_i[j] &
                 (stg_dest_i[j*REG_W +: REG_W] == src_i);
    end
  end

  // Scan oldest to youngest so the lowest-index match wins.
  always_comb begin
    sel_o = '0;
    for (int j = NR - 2; j >= 0; j--) begin
      if (match[j]) sel_o = SEL_W'(j + 1);
    end
  end

  assign hit_o       = |match;
  assign hit_first_o = match[0];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory/fetch stalls, load-use or RAW interlock,
// operand forwarding select, branch redirect with stale-fetch drain, and a
// saturating stall-cycle counter.
// Build option: define PIPE_HAZARD_CTRL_FWD_EN to enable forwarding; without
// it every RAW match interlocks and fwd_sel1/2 read the regfile.
//
// state | meaning
// RUN   | normal fetch; imem_resp data is accepted into register 0
// DRAIN | a redirect left a stale fetch in flight; its response is dropped
module pipe_hazard_ctrl
  import lc3b_types::*;
#(
  parameter  int NUM_STAGES = LC3B_NUM_STAGES,
  parameter  int REG_W      = 3,
  parameter  int BR_REG     = 2,
  localparam int NR         = NUM_STAGES - 1,
  localparam int SEL_W      = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_resp,
  input  logic                  dmem_req,
  input  logic                  dmem_resp,
  input  logic                  br_taken,
  input  logic [REG_W-1:0]      id_sr1,
  input  logic [REG_W-1:0]      id_sr2,
  input  logic                  id_sr1_used,
  input  logic                  id_sr2_used,
  input  logic [NR*REG_W-1:0]   stg_dest,
  input  logic [NR-1:0]         stg_wr,
  input  logic [NR-1:0]         stg_load,
  output logic [NR-1:0]         load_pipe,
  output logic [NR-1:0]         stg_valid,
  output logic                  pc_load,
  output logic                  redirect,
  output logic [SEL_W-1:0]      fwd_sel1,
  output logic [SEL_W-1:0]      fwd_sel2,
  output logic [15:0]           stall_cycles
);

  pipe_fsm_t       state_q, state_d;
  logic [NR-1:0]   valid_q, valid_d;
  logic [15:0]     stall_q, stall_d;

  logic            mem_stall, branch, data_stall, stall_evt;
  logic [SEL_W-1:0] sel1, sel2;
  logic            hit_any1, hit_any2, hit_first1, hit_first2;
  logic            unused_sink;

  pipe_fwd_sel #(.NUM_STAGES(NUM_STAGES), .REG_W(REG_W)) u_fwd_sr1 (
    .src_i       (id_sr1),
    .src_used_i  (id_sr1_used),
    .stg_valid_i (valid_q[NR-1:1]),
    .stg_wr_i    (stg_wr[NR-1:1]),
    .stg_dest_i  (stg_dest[NR*REG_W-1:REG_W]),
    .sel_o       (sel1),
    .hit_o       (hit_any1),
    .hit_first_o (hit_first1)
  );

  pipe_fwd_sel #(.NUM_STAGES(NUM_STAGES), .REG_W(REG_W)) u_fwd_sr2 (
    .src_i       (id_sr2),
    .src_used_i  (id_sr2_used),
    .stg_valid_i (valid_q[NR-1:1]),
    .stg_wr_i    (stg_wr[NR-1:1]),
    .stg_dest_i  (stg_dest[NR*REG_W-1:REG_W]),
    .sel_o       (sel2),
    .hit_o       (hit_any2),
    .hit_first_o (hit_first2)
  );

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  // Only a load sitting right behind ID cannot be forwarded in time.
  assign data_stall  = (hit_first1 | hit_first2) & stg_load[1];
  assign fwd_sel1    = sel1;
  assign fwd_sel2    = sel2;
  assign unused_sink = ^{stg_dest[REG_W-1:0], stg_wr[0], stg_load[0],
                         stg_load[NR-1:2], hit_any1, hit_any2};
`else
  // No bypass network: any pending producer blocks ID until it retires.
  assign data_stall  = hit_any1 | hit_any2;
  assign fwd_sel1    = '0;
  assign fwd_sel2    = '0;
  assign unused_sink = ^{stg_dest[REG_W-1:0], stg_wr[0], stg_load,
                         sel1, sel2, hit_first1, hit_first2};
`endif

  assign mem_stall = valid_q[NUM_STAGES-3] & dmem_req & ~dmem_resp;
  assign branch    = valid_q[BR_REG] & br_taken & ~mem_stall;

  // Next-state and pipeline control; priority is reset, mem stall, redirect,
  // data hazard, then fetch miss / drain.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    load_pipe = '0;
    pc_load   = 1'b0;
    redirect  = 1'b0;
    stall_evt = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
    end else if (mem_stall) begin
      stall_evt = 1'b1;
    end else if (branch) begin
      redirect  = 1'b1;
      pc_load   = 1'b1;
      load_pipe = '1;
      valid_d   = '0;
      for (int k = BR_REG + 1; k < NR; k++) valid_d[k] = valid_q[k-1];
      state_d   = imem_resp ? RUN : DRAIN;
    end else begin
      load_pipe = '1;
      for (int k = 1; k < NR; k++) valid_d[k] = valid_q[k-1];
      if (data_stall) begin
        load_pipe[0] = 1'b0;
        valid_d[0]   = valid_q[0];
        valid_d[1]   = 1'b0;
        stall_evt    = 1'b1;
      end else if (state_q == DRAIN || !imem_resp) begin
        valid_d[0] = 1'b0;
        stall_evt  = ~imem_resp;
      end else begin
        valid_d[0] = 1'b1;
        pc_load    = 1'b1;
      end
      if (state_q == DRAIN && imem_resp) state_d = RUN;
    end
    stall_d = (stall_evt && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      valid_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign stg_valid    = valid_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl (NUM_STAGES=5, BR_REG=2).
module tb_pipe_hazard_ctrl;

  localparam int RW = 3;
  localparam int NR = 4;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, imem_resp, dmem_req, dmem_resp, br_taken;
  logic [RW-1:0]  id_sr1, id_sr2;
  logic           id_sr1_used, id_sr2_used;
  logic [NR*RW-1:0] stg_dest;
  logic [NR-1:0]  stg_wr, stg_load, load_pipe, stg_valid;
  logic           pc_load, redirect;
  logic [SW-1:0]  fwd_sel1, fwd_sel2;
  logic [15:0]    stall_cycles;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .br_taken(br_taken), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used), .stg_dest(stg_dest),
    .stg_wr(stg_wr), .stg_load(stg_load), .load_pipe(load_pipe),
    .stg_valid(stg_valid), .pc_load(pc_load), .redirect(redirect),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic rst, im, dq, dr, br;
    logic [2:0] s1; logic u1; logic [2:0] s2; logic u2;
    logic [11:0] dest; logic [3:0] wr, ld;
    logic [3:0] e_ld, e_v; logic e_pc, e_rd; logic [2:0] e_f1, e_f2; logic [15:0] e_st;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic v(input logic rst, im, dq, dr, br,
                   input logic [2:0] s1, input logic u1, input logic [2:0] s2, input logic u2,
                   input logic [11:0] dest, input logic [3:0] wr, ld,
                   input logic [3:0] e_ld, e_v, input logic e_pc, e_rd,
                   input logic [2:0] e_f1, e_f2, input logic [15:0] e_st);
    vec_t t;
    t.rst = rst; t.im = im; t.dq = dq; t.dr = dr; t.br = br;
    t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2;
    t.dest = dest; t.wr = wr; t.ld = ld;
    t.e_ld = e_ld; t.e_v = e_v; t.e_pc = e_pc; t.e_rd = e_rd;
    t.e_f1 = e_f1; t.e_f2 = e_f2; t.e_st = e_st;
    vq.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    rst_n = t.rst; imem_resp = t.im; dmem_req = t.dq; dmem_resp = t.dr; br_taken = t.br;
    id_sr1 = t.s1; id_sr1_used = t.u1; id_sr2 = t.s2; id_sr2_used = t.u2;
    stg_dest = t.dest; stg_wr = t.wr; stg_load = t.ld;
  endtask

  task automatic check(input string nm, input logic [3:0] e_ld, e_v, input logic e_pc, e_rd,
                       input logic [2:0] e_f1, e_f2, input logic [15:0] e_st);
    n_vec++;
    if ({load_pipe, stg_valid, pc_load, redirect, fwd_sel1, fwd_sel2, stall_cycles} !==
        {e_ld, e_v, e_pc, e_rd, e_f1, e_f2, e_st}) begin
      n_err++;
      $display("FAIL %s: got ld=%b v=%b pc=%b rd=%b f1=%0d f2=%0d st=%0d, want ld=%b v=%b pc=%b rd=%b f1=%0d f2=%0d st=%0d",
               nm, load_pipe, stg_valid, pc_load, redirect, fwd_sel1, fwd_sel2, stall_cycles,
               e_ld, e_v, e_pc, e_rd, e_f1, e_f2, e_st);
    end
  endtask

  localparam logic [11:0] D0 = 12'h000;

  initial begin
    // rst im dq dr br | s1 u1 s2 u2 | dest wr ld | e_ld e_v pc rd f1 f2 st
    v(0,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b0000,4'b0000,0,0,0,0,16'd0);  // reset
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0000,1,0,0,0,16'd0);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0001,1,0,0,0,16'd0);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0011,1,0,0,0,16'd0);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0111,1,0,0,0,16'd0);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1111,1,0,0,0,16'd0);
    v(1,0,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1111,0,0,0,0,16'd0);  // fetch miss
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1110,1,0,0,0,16'd1);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1101,1,0,0,0,16'd1);
    v(1,1,1,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1011,1,0,0,0,16'd1);  // dmem_req, EX/MEM empty
    v(1,1,1,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b0000,4'b0111,0,0,0,0,16'd1);  // mem stall x4
    v(1,1,1,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b0000,4'b0111,0,0,0,0,16'd2);
    v(1,1,1,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b0000,4'b0111,0,0,0,0,16'd3);
    v(1,1,1,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b0000,4'b0111,0,0,0,0,16'd4);
    v(1,1,1,1,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0111,1,0,0,0,16'd5);  // dmem done
    v(1,0,0,0,1, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1111,1,1,0,0,16'd5);  // redirect, fetch out
    v(1,0,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1000,0,0,0,0,16'd5);  // drain, still waiting
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0000,0,0,0,0,16'd6);  // stale resp dropped
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0000,1,0,0,0,16'd6);  // back in RUN
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0001,1,0,0,0,16'd6);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0011,1,0,0,0,16'd6);
    v(1,1,1,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b0000,4'b0111,0,0,0,0,16'd6);  // mem stall
    v(0,1,1,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b0000,4'b0111,0,0,0,0,16'd7);  // reset mid-stall
    v(1,1,1,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0000,1,0,0,0,16'd0);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0001,1,0,0,0,16'd0);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0011,1,0,0,0,16'd0);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0111,1,0,0,0,16'd0);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1111,1,0,0,0,16'd0);
    // sources matching but not used: no stall, no forward
    v(1,1,0,0,0, 1,0,5,0, {3'd1,3'd5,3'd1,3'd0},4'b1110,4'h0, 4'b1111,4'b1111,1,0,0,0,16'd0);
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    v(1,1,0,0,0, 1,1,5,1, {3'd1,3'd5,3'd1,3'd0},4'b1110,4'h0, 4'b1111,4'b1111,1,0,1,2,16'd0);  // ADD fwd
    v(1,1,0,0,0, 2,1,0,0, {3'd0,3'd0,3'd2,3'd0},4'b0010,4'b0010, 4'b1110,4'b1111,0,0,1,0,16'd0);  // LDR bubble
    v(1,1,0,0,0, 2,1,0,0, {3'd0,3'd2,3'd0,3'd0},4'b0100,4'b0100, 4'b1111,4'b1101,1,0,2,0,16'd1);  // then fwd 2
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1011,1,0,0,0,16'd1);
    v(1,1,0,0,1, 3,1,0,0, {3'd0,3'd0,3'd3,3'd0},4'b0010,4'b0010, 4'b1111,4'b0111,1,1,1,0,16'd1);  // redirect beats load-use
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1000,1,0,0,0,16'd1);
`else
    v(1,1,0,0,0, 2,1,0,0, {3'd0,3'd0,3'd2,3'd0},4'b0010,4'b0010, 4'b1110,4'b1111,0,0,0,0,16'd0);  // LDR bubble 1
    v(1,1,0,0,0, 2,1,0,0, {3'd0,3'd2,3'd0,3'd0},4'b0100,4'b0100, 4'b1110,4'b1101,0,0,0,0,16'd1);  // bubble 2
    v(1,1,0,0,0, 2,1,0,0, {3'd2,3'd0,3'd0,3'd0},4'b1000,4'b1000, 4'b1110,4'b1001,0,0,0,0,16'd2);  // bubble 3
    v(1,1,0,0,0, 2,1,0,0, D0,4'h0,4'h0, 4'b1111,4'b0001,1,0,0,0,16'd3);
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b0011,1,0,0,0,16'd3);
    v(1,1,0,0,1, 3,1,0,0, {3'd0,3'd0,3'd3,3'd0},4'b0010,4'b0000, 4'b1111,4'b0111,1,1,0,0,16'd3);  // redirect beats RAW
    v(1,1,0,0,0, 0,0,0,0, D0,4'h0,4'h0, 4'b1111,4'b1000,1,0,0,0,16'd3);
`endif

    drive(vq[0]);
    repeat (2) @(posedge clk);
    foreach (vq[i]) begin
      @(posedge clk);
      #1 drive(vq[i]);
      #1 check($sformatf("vec%0d", i), vq[i].e_ld, vq[i].e_v, vq[i].e_pc, vq[i].e_rd,
               vq[i].e_f1, vq[i].e_f2, vq[i].e_st);
    end

    // Saturation: reset, then continuous fetch misses.
    @(posedge clk);
    #1 drive(vq[0]);
    @(posedge clk);
    #1 rst_n = 1'b1; imem_resp = 1'b0;
    repeat (65534) @(posedge clk);
    #1 check("sat_fffe", 4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0, 16'hFFFE);
    @(posedge clk);
    #1 check("sat_ffff", 4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0, 16'hFFFF);
    repeat (4465) @(posedge clk);
    #1 check("sat_hold", 4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
